// File: rtl/lifo_param_stack.sv
// Parametrised LIFO operand stack with registered top/next-from-top, atomic replace,
// synchronous clear and sticky overflow/underflow flags.
//
// Per-cycle operation (decoded from CLEAR/I_VALID/O_EN and occupancy):
//    op          | meaning
//    OP_IDLE     | no request; O_VALID drops, everything else holds
//    OP_CLEAR    | empty the stack, clear sticky flags, O_DATA held
//    OP_PUSH     | store I_DATA on top, old top moves to next, next spills to memory
//    OP_PUSH_UDF | push+pop on empty stack: push accepted, pop refused
//    OP_OVF      | push on full stack dropped
//    OP_POP      | emit top, next becomes top, memory refills next
//    OP_UDF      | pop on empty stack refused
//    OP_REPL     | push+pop with entries present: emit top, I_DATA replaces top
module lifo_param_stack #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 1024,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             CLEAR,
   input  logic             I_VALID,
   input  logic [WIDTH-1:0] I_DATA,
   input  logic             O_EN,
   output logic             O_VALID,
   output logic [WIDTH-1:0] O_DATA,
   output logic [WIDTH-1:0] TOP_DATA,
   output logic [WIDTH-1:0] NEXT_DATA,
   output logic [CW-1:0]    COUNT,
   output logic             FULL,
   output logic             EMPTY,
   output logic             OVF,
   output logic             UDF
);

   // Memory holds only the entries below NEXT_DATA, i.e. stack positions 0..COUNT-3.
   localparam int MEM_D = (DEPTH > 2) ? DEPTH - 2 : 1;
   localparam int AW    = (MEM_D > 1) ? $clog2(MEM_D) : 1;

   typedef enum logic [2:0] {
      OP_IDLE,
      OP_CLEAR,
      OP_PUSH,
      OP_PUSH_UDF,
      OP_OVF,
      OP_POP,
      OP_UDF,
      OP_REPL
   } op_e;

   logic [WIDTH-1:0] mem [MEM_D];

   logic [CW-1:0]    count_q;
   logic [WIDTH-1:0] top_q;
   logic [WIDTH-1:0] next_q;
   logic [WIDTH-1:0] o_data_q;
   logic             o_valid_q;
   logic             ovf_q;
   logic             udf_q;

   op_e              op;
   logic             is_full;
   logic             is_empty;
   logic             count_ge2;
   logic             count_ge3;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [WIDTH-1:0] rd_data;

   assign is_full   = (count_q == CW'(DEPTH));
   assign is_empty  = (count_q == '0);
   assign count_ge2 = (count_q >= CW'(2));
   assign count_ge3 = (count_q >= CW'(3));

   assign wr_ptr  = AW'(count_q) - AW'(2);
   assign rd_ptr  = AW'(count_q) - AW'(3);
   // Asynchronous read so NEXT_DATA refills in the same cycle as the pop.
   assign rd_data = mem[rd_ptr];

   always_comb begin
      op = OP_IDLE;
      if (CLEAR) begin
         op = OP_CLEAR;
      end else if (I_VALID && O_EN) begin
         op = is_empty ? OP_PUSH_UDF : OP_REPL;
      end else if (I_VALID) begin
         op = is_full ? OP_OVF : OP_PUSH;
      end else if (O_EN) begin
         op = is_empty ? OP_UDF : OP_POP;
      end
   end

   always_ff @(posedge CLK) begin
      if ((op == OP_PUSH) && count_ge2) begin
         mem[wr_ptr] <= next_q;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         count_q   <= '0;
         top_q     <= '0;
         next_q    <= '0;
         o_data_q  <= '0;
         o_valid_q <= 1'b0;
         ovf_q     <= 1'b0;
         udf_q     <= 1'b0;
      end else begin
         o_valid_q <= 1'b0;
         case (op)
            OP_CLEAR: begin
               count_q <= '0;
               top_q   <= '0;
               next_q  <= '0;
               ovf_q   <= 1'b0;
               udf_q   <= 1'b0;
            end
            OP_PUSH, OP_PUSH_UDF: begin
               count_q <= count_q + CW'(1);
               top_q   <= I_DATA;
               next_q  <= top_q;
               if (op == OP_PUSH_UDF) begin
                  udf_q <= 1'b1;
               end
            end
            OP_OVF: begin
               ovf_q <= 1'b1;
            end
            OP_POP: begin
               o_data_q  <= top_q;
               o_valid_q <= 1'b1;
               count_q   <= count_q - CW'(1);
               top_q     <= next_q;
               next_q    <= count_ge3 ? rd_data : '0;
            end
            OP_UDF: begin
               udf_q <= 1'b1;
            end
            OP_REPL: begin
               o_data_q  <= top_q;
               o_valid_q <= 1'b1;
               top_q     <= I_DATA;
            end
            default: begin
            end
         endcase
      end
   end

   assign O_VALID   = o_valid_q;
   assign O_DATA    = o_data_q;
   assign TOP_DATA  = top_q;
   assign NEXT_DATA = next_q;
   assign COUNT     = count_q;
   assign FULL      = is_full;
   assign EMPTY     = is_empty;
   assign OVF       = ovf_q;
   assign UDF       = udf_q;

endmodule

// File: tb/tb_lifo_param_stack.sv
// Bench for lifo_param_stack (WIDTH=8, DEPTH=4): directed scenarios plus random
// traffic compared against a queue-based model of the stack.
module tb_lifo_param_stack;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             CLK = 1'b0;
   logic             RST_N;
   logic             CLEAR;
   logic             I_VALID;
   logic [WIDTH-1:0] I_DATA;
   logic             O_EN;
   logic             O_VALID;
   logic [WIDTH-1:0] O_DATA;
   logic [WIDTH-1:0] TOP_DATA;
   logic [WIDTH-1:0] NEXT_DATA;
   logic [CW-1:0]    COUNT;
   logic             FULL;
   logic             EMPTY;
   logic             OVF;
   logic             UDF;

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0] m_q[$];
   logic             m_ovf, m_udf, m_ov;
   logic [WIDTH-1:0] m_od;

   always #5 CLK = ~CLK;

   lifo_param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .CLK(CLK), .RST_N(RST_N), .CLEAR(CLEAR), .I_VALID(I_VALID), .I_DATA(I_DATA),
      .O_EN(O_EN), .O_VALID(O_VALID), .O_DATA(O_DATA), .TOP_DATA(TOP_DATA),
      .NEXT_DATA(NEXT_DATA), .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY),
      .OVF(OVF), .UDF(UDF)
   );

   function automatic logic [WIDTH-1:0] m_top();
      return (m_q.size() > 0) ? m_q[m_q.size()-1] : '0;
   endfunction

   function automatic logic [WIDTH-1:0] m_next();
      return (m_q.size() > 1) ? m_q[m_q.size()-2] : '0;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_ovf = 0; m_udf = 0; m_ov = 0; m_od = '0;
   endtask

   task automatic model_step(input logic clr, input logic iv, input logic [WIDTH-1:0] id,
                             input logic oe);
      if (clr) begin
         m_q.delete(); m_ovf = 0; m_udf = 0; m_ov = 0;
      end else if (iv && oe) begin
         if (m_q.size() > 0) begin
            m_od = m_q[m_q.size()-1]; m_ov = 1; m_q[m_q.size()-1] = id;
         end else begin
            m_q.push_back(id); m_udf = 1; m_ov = 0;
         end
      end else if (iv) begin
         m_ov = 0;
         if (m_q.size() == DEPTH) m_ovf = 1;
         else m_q.push_back(id);
      end else if (oe) begin
         if (m_q.size() > 0) begin
            m_od = m_q.pop_back(); m_ov = 1;
         end else begin
            m_ov = 0; m_udf = 1;
         end
      end else begin
         m_ov = 0;
      end
   endtask

   // One clock cycle of stimulus; outputs are sampled 1ns after the edge by the caller.
   task automatic cycle(input logic clr, input logic iv, input logic [WIDTH-1:0] id,
                        input logic oe);
      @(negedge CLK);
      CLEAR = clr; I_VALID = iv; I_DATA = id; O_EN = oe;
      model_step(clr, iv, id, oe);
      @(posedge CLK);
      #1;
      CLEAR = 0; I_VALID = 0; O_EN = 0;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST_N = 0;
      model_reset();
      @(negedge CLK);
      RST_N = 1;
   endtask

   task automatic test_reset();
      do_reset();
      cycle(0, 1, 8'h11, 0);
      cycle(0, 1, 8'h22, 0);
      checks++;
      if (COUNT !== 3'd2 || TOP_DATA !== 8'h22 || NEXT_DATA !== 8'h11) begin
         errors++;
         $display("FAIL reset_pre: count=%0d top=%h next=%h, want 2/22/11", COUNT, TOP_DATA, NEXT_DATA);
      end
      @(negedge CLK);
      #2 RST_N = 0;
      model_reset();
      #1;
      checks++;
      if (COUNT !== 3'd0 || TOP_DATA !== 8'h00 || NEXT_DATA !== 8'h00 || O_VALID !== 1'b0 ||
          EMPTY !== 1'b1 || OVF !== 1'b0 || UDF !== 1'b0 || O_DATA !== 8'h00) begin
         errors++;
         $display("FAIL reset_async: count=%0d top=%h next=%h ov=%b empty=%b ovf=%b udf=%b od=%h, want 0/00/00/0/1/0/0/00",
                  COUNT, TOP_DATA, NEXT_DATA, O_VALID, EMPTY, OVF, UDF, O_DATA);
      end
      @(negedge CLK);
      RST_N = 1;
   endtask

   task automatic test_lifo_order();
      logic [WIDTH-1:0] exp_o[4];
      exp_o = '{8'h44, 8'h33, 8'h22, 8'h11};
      cycle(1, 0, 0, 0);
      cycle(0, 1, 8'h11, 0);
      cycle(0, 1, 8'h22, 0);
      cycle(0, 1, 8'h33, 0);
      cycle(0, 1, 8'h44, 0);
      checks++;
      if (COUNT !== 3'd4 || FULL !== 1'b1) begin
         errors++;
         $display("FAIL fill: count=%0d full=%b, want 4/1", COUNT, FULL);
      end
      for (int i = 0; i < 4; i++) begin
         cycle(0, 0, 0, 1);
         checks++;
         if (O_VALID !== 1'b1 || O_DATA !== exp_o[i]) begin
            errors++;
            $display("FAIL pop_%0d: ov=%b od=%h, want 1/%h", i, O_VALID, O_DATA, exp_o[i]);
         end
         if (i == 0) begin
            checks++;
            if (TOP_DATA !== 8'h33 || NEXT_DATA !== 8'h22) begin
               errors++;
               $display("FAIL pop_track: top=%h next=%h, want 33/22", TOP_DATA, NEXT_DATA);
            end
         end
      end
      cycle(0, 0, 0, 0);
      checks++;
      if (EMPTY !== 1'b1 || O_VALID !== 1'b0 || O_DATA !== 8'h11 || TOP_DATA !== 8'h00) begin
         errors++;
         $display("FAIL drained: empty=%b ov=%b od=%h top=%h, want 1/0/11/00", EMPTY, O_VALID, O_DATA, TOP_DATA);
      end
   endtask

   task automatic test_overflow();
      cycle(1, 0, 0, 0);
      cycle(0, 1, 8'h11, 0);
      cycle(0, 1, 8'h22, 0);
      cycle(0, 1, 8'h33, 0);
      cycle(0, 1, 8'h44, 0);
      cycle(0, 1, 8'h55, 0);
      checks++;
      if (COUNT !== 3'd4 || TOP_DATA !== 8'h44 || OVF !== 1'b1) begin
         errors++;
         $display("FAIL overflow: count=%0d top=%h ovf=%b, want 4/44/1", COUNT, TOP_DATA, OVF);
      end
      cycle(0, 0, 0, 1);
      checks++;
      if (O_VALID !== 1'b1 || O_DATA !== 8'h44 || OVF !== 1'b1 || COUNT !== 3'd3) begin
         errors++;
         $display("FAIL overflow_pop: ov=%b od=%h ovf=%b count=%0d, want 1/44/1/3", O_VALID, O_DATA, OVF, COUNT);
      end
   endtask

   task automatic test_underflow_replace();
      cycle(1, 0, 0, 0);
      cycle(0, 0, 0, 1);
      checks++;
      if (O_VALID !== 1'b0 || UDF !== 1'b1 || COUNT !== 3'd0) begin
         errors++;
         $display("FAIL underflow: ov=%b udf=%b count=%0d, want 0/1/0", O_VALID, UDF, COUNT);
      end
      cycle(0, 1, 8'h66, 1);
      checks++;
      if (COUNT !== 3'd1 || TOP_DATA !== 8'h66 || O_VALID !== 1'b0 || NEXT_DATA !== 8'h00) begin
         errors++;
         $display("FAIL replace_empty: count=%0d top=%h ov=%b next=%h, want 1/66/0/00", COUNT, TOP_DATA, O_VALID, NEXT_DATA);
      end
   endtask

   task automatic test_replace_full();
      cycle(1, 0, 0, 0);
      cycle(0, 1, 8'h11, 0);
      cycle(0, 1, 8'h22, 0);
      cycle(0, 1, 8'h33, 0);
      cycle(0, 1, 8'h44, 0);
      cycle(0, 1, 8'h99, 1);
      checks++;
      if (O_DATA !== 8'h44 || O_VALID !== 1'b1 || TOP_DATA !== 8'h99 || NEXT_DATA !== 8'h33 ||
          COUNT !== 3'd4 || OVF !== 1'b0) begin
         errors++;
         $display("FAIL replace_full: od=%h ov=%b top=%h next=%h count=%0d ovf=%b, want 44/1/99/33/4/0",
                  O_DATA, O_VALID, TOP_DATA, NEXT_DATA, COUNT, OVF);
      end
      cycle(0, 0, 0, 1);
      checks++;
      if (O_DATA !== 8'h99 || TOP_DATA !== 8'h33 || NEXT_DATA !== 8'h22) begin
         errors++;
         $display("FAIL replace_then_pop: od=%h top=%h next=%h, want 99/33/22", O_DATA, TOP_DATA, NEXT_DATA);
      end
   endtask

   task automatic test_clear();
      cycle(1, 0, 0, 0);
      cycle(0, 1, 8'h11, 0);
      cycle(0, 1, 8'h22, 0);
      cycle(0, 1, 8'h33, 0);
      cycle(0, 1, 8'h44, 0);
      cycle(0, 1, 8'h55, 0);
      cycle(0, 0, 0, 1);
      checks++;
      if (COUNT !== 3'd3 || OVF !== 1'b1) begin
         errors++;
         $display("FAIL clear_pre: count=%0d ovf=%b, want 3/1", COUNT, OVF);
      end
      cycle(1, 1, 8'h77, 0);
      checks++;
      if (COUNT !== 3'd0 || OVF !== 1'b0 || TOP_DATA !== 8'h00 || NEXT_DATA !== 8'h00 ||
          O_VALID !== 1'b0 || O_DATA !== 8'h44) begin
         errors++;
         $display("FAIL clear: count=%0d ovf=%b top=%h next=%h ov=%b od=%h, want 0/0/00/00/0/44",
                  COUNT, OVF, TOP_DATA, NEXT_DATA, O_VALID, O_DATA);
      end
      cycle(0, 0, 0, 0);
      checks++;
      if (COUNT !== 3'd0 || EMPTY !== 1'b1) begin
         errors++;
         $display("FAIL clear_nostore: count=%0d empty=%b, want 0/1", COUNT, EMPTY);
      end
   endtask

   task automatic test_random();
      logic clr, iv, oe;
      logic [WIDTH-1:0] id;
      do_reset();
      for (int n = 0; n < 600; n++) begin
         clr = ($urandom_range(0, 99) < 3);
         iv  = $urandom_range(0, 1);
         oe  = $urandom_range(0, 1);
         id  = WIDTH'($urandom);
         cycle(clr, iv, id, oe);
         checks++;
         if (COUNT !== CW'(m_q.size()) || TOP_DATA !== m_top() || NEXT_DATA !== m_next() ||
             O_VALID !== m_ov || O_DATA !== m_od || OVF !== m_ovf || UDF !== m_udf ||
             FULL !== (m_q.size() == DEPTH) || EMPTY !== (m_q.size() == 0)) begin
            errors++;
            $display("FAIL random_%0d: count=%0d top=%h next=%h ov=%b od=%h ovf=%b udf=%b full=%b empty=%b, want %0d/%h/%h/%b/%h/%b/%b/%b/%b",
                     n, COUNT, TOP_DATA, NEXT_DATA, O_VALID, O_DATA, OVF, UDF, FULL, EMPTY,
                     m_q.size(), m_top(), m_next(), m_ov, m_od, m_ovf, m_udf,
                     m_q.size() == DEPTH, m_q.size() == 0);
         end
      end
   endtask

   initial begin
      RST_N = 0; CLEAR = 0; I_VALID = 0; I_DATA = '0; O_EN = 0;
      model_reset();
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST_N = 1;
      test_reset();
      test_lifo_order();
      test_overflow();
      test_underflow_replace();
      test_replace_full();
      test_clear();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
